acc_addsub_4bit: RTL and testbench
==================================

ACC_ADDSUB_4BIT -- requirements
Module: acc_addsub_4bit

Interface
REQ-001 SHALL have parameter: W, 4, accumulator and operand width in bits (legal: 4..16).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: in_valid  input  1  operation request valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept a request.
REQ-006 SHALL have port: op  input  2  operation: 00 LOAD, 01 ADD, 10 SUB, 11 CLR.
REQ-007 SHALL have port: operand  input  W  two's-complement operand B.
REQ-008 SHALL have port: out_valid  output  1  result and flags valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port: acc  output  W  accumulator value.
REQ-011 SHALL have port: cout  output  1  carry out; for SUB, 1 means no borrow.
REQ-012 SHALL have port: ovf  output  1  signed overflow of the last ADD/SUB.
REQ-013 SHALL have port: zero  output  1  acc equals 0.

Function
REQ-014 SHALL implement a 3-state FSM: IDLE, EXEC, HOLD.
REQ-015 SHALL assert in_ready only in IDLE; in_valid & in_ready at an edge captures op and operand and moves to EXEC.
REQ-016 SHALL in EXEC compute acc + operand (ADD, carry-in 0) or acc + ~operand + 1 (SUB, carry-in 1); at the next edge update acc, cout, ovf, zero and move to HOLD.
REQ-017 SHALL for LOAD set acc=operand; for CLR set acc=0; both clear cout and ovf.
REQ-018 SHALL assert out_valid only in HOLD; first out_valid appears two edges after acceptance.
REQ-019 SHALL hold acc and all flags stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-020 SHALL return to IDLE on the edge where out_valid & out_ready; in_valid is not sampled in that cycle.
REQ-021 SHALL compute ovf as carry-into-MSB XOR carry-out-of-MSB; results wrap modulo 2^W.
REQ-022 SHALL derive zero combinationally from the registered acc.
REQ-023 SHALL ignore op, operand and in_valid outside IDLE.

Reset
REQ-024 SHALL on rst_n low, immediately and regardless of state, force state=IDLE, acc=0, cout=0, ovf=0, out_valid=0; zero reads 1.
REQ-025 SHALL discard any in-flight operation when reset asserts in EXEC or HOLD; in_ready=1 on the first edge after rst_n deasserts.

Configuration
REQ-026 SHALL support macro ACC_ADDSUB_SAT_EN: when defined, signed overflow clamps acc to 2^(W-1)-1 (positive overflow) or -2^(W-1) (negative overflow), with ovf=1.
REQ-027 SHALL, when ACC_ADDSUB_SAT_EN is undefined, wrap per REQ-021 with no clamping logic present.

Structure
REQ-028 SHALL place the op encodings (LOAD/ADD/SUB/CLR), FSM state encodings and the default W in shared package acc_addsub_pkg.
REQ-029 SHALL implement the arithmetic in one sub-module, acc_addsub_core: W-bit ripple add/sub, sel 0 add / 1 subtract, carry-in tied to sel, outputs sum, cout, ovf.
REQ-030 SHALL keep FSM, registers and saturation in acc_addsub_4bit; the core stays purely combinational.

Verification (W=4)
REQ-031 SHALL cover reset: rst_n low during HOLD -> acc=0000, zero=1, out_valid=0; in_ready=1 after release.
REQ-032 SHALL cover add overflow: LOAD 0101, ADD 0011 -> acc=1000, cout=0, ovf=1; with ACC_ADDSUB_SAT_EN acc=0111, ovf=1.
REQ-033 SHALL cover borrow: LOAD 0011, SUB 0101 -> acc=1110, cout=0, ovf=0, zero=0.
REQ-034 SHALL cover equal subtract: LOAD 0110, SUB 0110 -> acc=0000, cout=1, ovf=0, zero=1.
REQ-035 SHALL cover backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, acc/flags stable, no op accepted; out_ready=1 -> IDLE next edge.
REQ-036 SHALL cover latency: accept at edge N -> out_valid=1 after edge N+1; CLR from acc=1011 -> acc=0000, cout=0, ovf=0.

Source files
------------

// File: rtl/acc_addsub_pkg.sv
// Shared definitions for the add/subtract accumulator: op codes, FSM states, default width.
package acc_addsub_pkg;

   localparam int ACC_W_DEFAULT = 4;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_ADD  = 2'b01,
      OP_SUB  = 2'b10,
      OP_CLR  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_HOLD = 2'b10
   } state_e;

endpackage

// File: rtl/acc_addsub_core.sv
// Purely combinational W-bit ripple adder/subtractor; sel=1 subtracts via a + ~b + 1.
module acc_addsub_core
   import acc_addsub_pkg::*;
#(
   parameter int W = ACC_W_DEFAULT
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sel,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         ovf
);

   logic [W:0]   carry_s;
   logic [W-1:0] bx_s;

   // Ripple chain; carry_s[i] is the carry into bit i, carry_s[0] doubles as the subtract carry-in.
   always_comb begin
      carry_s    = {(W+1){1'b0}};
      sum        = {W{1'b0}};
      bx_s       = b ^ {W{sel}};
      carry_s[0] = sel;
      for (int i = 0; i < W; i++) begin
         sum[i]       = a[i] ^ bx_s[i] ^ carry_s[i];
         carry_s[i+1] = (a[i] & bx_s[i]) | (carry_s[i] & (a[i] ^ bx_s[i]));
      end
   end

   assign cout = carry_s[W];
   assign ovf  = carry_s[W] ^ carry_s[W-1];

endmodule

// File: rtl/acc_addsub_4bit.sv
// Handshaked accumulator (LOAD/ADD/SUB/CLR) with IDLE/EXEC/HOLD control.
// Define ACC_ADDSUB_SAT_EN to clamp signed overflow instead of wrapping.
module acc_addsub_4bit
   import acc_addsub_pkg::*;
#(
   parameter int W = ACC_W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   op,
   input  logic [W-1:0] operand,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] acc,
   output logic         cout,
   output logic         ovf,
   output logic         zero
);

   state_e       state_r;
   op_e          op_r;
   logic [W-1:0] operand_r;
   logic [W-1:0] acc_r;
   logic         cout_r;
   logic         ovf_r;
   logic         in_ready_r;
   logic         out_valid_r;

   logic [W-1:0] core_sum_s;
   logic         core_cout_s;
   logic         core_ovf_s;
   logic         core_sel_s;
   logic [W-1:0] acc_nxt_s;
   logic         cout_nxt_s;
   logic         ovf_nxt_s;

   assign core_sel_s = (op_r == OP_SUB);

   acc_addsub_core #(
      .W (W)
   ) u_core (
      .a    (acc_r),
      .b    (operand_r),
      .sel  (core_sel_s),
      .sum  (core_sum_s),
      .cout (core_cout_s),
      .ovf  (core_ovf_s)
   );

   // Result selection for the captured op; LOAD and CLR leave both flags cleared.
   always_comb begin
      acc_nxt_s  = acc_r;
      cout_nxt_s = 1'b0;
      ovf_nxt_s  = 1'b0;
      case (op_r)
         OP_LOAD: begin
            acc_nxt_s = operand_r;
         end
         OP_ADD, OP_SUB: begin
            cout_nxt_s = core_cout_s;
            ovf_nxt_s  = core_ovf_s;
`ifdef ACC_ADDSUB_SAT_EN
            // A wrapped sum with MSB set can only come from a positive overflow.
            if (core_ovf_s) begin
               if (core_sum_s[W-1]) begin
                  acc_nxt_s = {1'b0, {(W-1){1'b1}}};
               end else begin
                  acc_nxt_s = {1'b1, {(W-1){1'b0}}};
               end
            end else begin
               acc_nxt_s = core_sum_s;
            end
`else
            acc_nxt_s = core_sum_s;
`endif
         end
         OP_CLR: begin
            acc_nxt_s = {W{1'b0}};
         end
         default: begin
            acc_nxt_s = {W{1'b0}};
         end
      endcase
   end

   // Control FSM with registered handshake outputs; result registers only change on EXEC->HOLD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         op_r        <= OP_LOAD;
         operand_r   <= {W{1'b0}};
         acc_r       <= {W{1'b0}};
         cout_r      <= 1'b0;
         ovf_r       <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  op_r       <= op_e'(op);
                  operand_r  <= operand;
                  in_ready_r <= 1'b0;
                  state_r    <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               acc_r       <= acc_nxt_s;
               cout_r      <= cout_nxt_s;
               ovf_r       <= ovf_nxt_s;
               out_valid_r <= 1'b1;
               state_r     <= ST_HOLD;
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign acc       = acc_r;
   assign cout      = cout_r;
   assign ovf       = ovf_r;
   assign zero      = (acc_r == {W{1'b0}});

endmodule

// File: tb/tb_acc_addsub_4bit.sv
// Scoreboard bench for acc_addsub_4bit at W=4; honours ACC_ADDSUB_SAT_EN when defined.
module tb_acc_addsub_4bit;

   typedef struct packed {
      logic [3:0] acc;
      logic       cout;
      logic       ovf;
      logic       zero;
   } res_t;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] op;
   logic [3:0] operand;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] acc;
   logic       cout;
   logic       ovf;
   logic       zero;

   int   checks = 0;
   int   errors = 0;
   res_t sb_q[$];
   logic [3:0] m_acc;

   acc_addsub_4bit #(.W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .operand   (operand),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .acc       (acc),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int s4(input logic [3:0] v);
      return v[3] ? int'(v) - 16 : int'(v);
   endfunction

   // Reference model: integer arithmetic for signed range, 5-bit sum for carry.
   task automatic model(input logic [1:0] o, input logic [3:0] b);
      res_t e;
      logic [4:0] s;
      int sr;
      e.cout = 1'b0;
      e.ovf  = 1'b0;
      case (o)
         2'b00: m_acc = b;
         2'b11: m_acc = 4'd0;
         default: begin
            if (o == 2'b01) begin
               s  = {1'b0, m_acc} + {1'b0, b};
               sr = s4(m_acc) + s4(b);
            end else begin
               s  = {1'b0, m_acc} + {1'b0, ~b} + 5'd1;
               sr = s4(m_acc) - s4(b);
            end
            e.cout = s[4];
            e.ovf  = (sr > 7) || (sr < -8);
            m_acc  = s[3:0];
`ifdef ACC_ADDSUB_SAT_EN
            if (sr > 7) m_acc = 4'b0111;
            else if (sr < -8) m_acc = 4'b1000;
`endif
         end
      endcase
      e.acc  = m_acc;
      e.zero = (m_acc == 4'd0);
      sb_q.push_back(e);
   endtask

   task automatic send(input logic [1:0] o, input logic [3:0] b);
      int n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_ready in_ready=%b required 1", in_ready);
      end
      in_valid = 1'b1;
      op       = o;
      operand  = b;
      model(o, b);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic collect(output res_t obs, output res_t e);
      int n = 0;
      e = '0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      obs = {acc, cout, ovf, zero};
      checks++;
      if (out_valid !== 1'b1 || sb_q.size() == 0) begin
         errors++;
         $display("FAIL collect out_valid=%b queued=%0d required out_valid=1 queued>0", out_valid, sb_q.size());
      end else begin
         e = sb_q.pop_front();
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({acc, cout, ovf, zero, out_valid} !== 8'b0000_0010) begin
         errors++;
         $display("FAIL reset_state acc/cout/ovf/zero/out_valid=%b required 00000010",
                  {acc, cout, ovf, zero, out_valid});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready in_ready=%b required 1", in_ready);
      end
   endtask

   task automatic test_add_overflow();
      res_t obs, e;
      send(2'b00, 4'b0101); collect(obs, e); release_out();
      send(2'b01, 4'b0011); collect(obs, e);
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL add_ovf_sb got=%b required=%b", obs, e);
      end
      checks++;
`ifdef ACC_ADDSUB_SAT_EN
      if (obs !== 7'b0111_0_1_0) begin
         errors++;
         $display("FAIL add_ovf_sat got=%b required=0111010", obs);
      end
`else
      if (obs !== 7'b1000_0_1_0) begin
         errors++;
         $display("FAIL add_ovf_wrap got=%b required=1000010", obs);
      end
`endif
      release_out();
   endtask

   task automatic test_borrow();
      res_t obs, e;
      send(2'b00, 4'b0011); collect(obs, e); release_out();
      send(2'b10, 4'b0101); collect(obs, e);
      checks++;
      if (obs !== 7'b1110_0_0_0 || obs !== e) begin
         errors++;
         $display("FAIL borrow got=%b required=1110000 model=%b", obs, e);
      end
      release_out();
   endtask

   task automatic test_equal_sub();
      res_t obs, e;
      send(2'b00, 4'b0110); collect(obs, e); release_out();
      send(2'b10, 4'b0110); collect(obs, e);
      checks++;
      if (obs !== 7'b0000_1_0_1 || obs !== e) begin
         errors++;
         $display("FAIL equal_sub got=%b required=0000101 model=%b", obs, e);
      end
      release_out();
   endtask

   task automatic test_backpressure();
      res_t obs, e, held;
      send(2'b00, 4'b0010); collect(held, e);
      checks++;
      if (held !== e) begin
         errors++;
         $display("FAIL bp_load got=%b required=%b", held, e);
      end
      in_valid = 1'b1;
      op       = 2'b01;
      operand  = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         obs = {acc, cout, ovf, zero};
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs !== held) begin
            errors++;
            $display("FAIL bp_hold cycle=%0d in_ready=%b out_valid=%b res=%b required 0 1 %b",
                     i, in_ready, out_valid, obs, held);
         end
      end
      // in_valid stays high across the release edge and must not be taken.
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      end
      in_valid = 1'b0;
      send(2'b01, 4'b0001); collect(obs, e);
      checks++;
      if (obs !== e || obs.acc !== 4'b0011) begin
         errors++;
         $display("FAIL bp_after got=%b required=%b", obs, e);
      end
      release_out();
   endtask

   task automatic test_latency_clr();
      res_t obs, e;
      send(2'b00, 4'b1011); collect(obs, e); release_out();
      send(2'b11, 4'b0101);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_n out_valid=%b required 0", out_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL latency_n1 out_valid=%b required 1", out_valid);
      end
      @(negedge clk);
      collect(obs, e);
      checks++;
      if (obs !== 7'b0000_0_0_1 || obs !== e) begin
         errors++;
         $display("FAIL clr got=%b required=0000001 model=%b", obs, e);
      end
      release_out();
   endtask

   task automatic test_reset_in_hold();
      res_t obs, e;
      send(2'b00, 4'b1010); collect(obs, e);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({acc, cout, ovf, zero, out_valid} !== 8'b0000_0010) begin
         errors++;
         $display("FAIL reset_hold acc/cout/ovf/zero/out_valid=%b required 00000010",
                  {acc, cout, ovf, zero, out_valid});
      end
      sb_q.delete();
      m_acc = 4'd0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold_release in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      res_t obs, e;
      for (int i = 0; i < 16; i++) begin
         send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
         collect(obs, e);
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL b2b_%0d got=%b required=%b", i, obs, e);
         end
         release_out();
      end
   endtask

   initial begin
      in_valid  = 1'b0;
      op        = 2'b00;
      operand   = 4'd0;
      out_ready = 1'b0;
      m_acc     = 4'd0;
      test_reset();
      test_add_overflow();
      test_borrow();
      test_equal_sub();
      test_backpressure();
      test_latency_clr();
      test_reset_in_hold();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

endmodule
